// File: rtl/exit_device_if.sv
// Data-bus request/response channel between the core (master) and the exit device (slave).
interface exit_device_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/exit_device.sv
// Memory-mapped test-exit ("tohost") device: a TOHOST store with bit0 set halts the run.
// Optional watchdog timeout exit is compiled in when EXIT_WATCHDOG_EN is defined.
module exit_device #(
    parameter int unsigned TIMEOUT      = 50000,
    parameter logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    exit_device_if.slave       bus,
    output logic               exit,
    output logic [31:0]        gp
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] gp_q, gp_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        accept;
    logic        tohost_store;
    logic [31:0] read_data;

    // Byte-lane bits are ignored; only word offsets decode.
    logic unused_addr;
    assign unused_addr = ^bus.req_addr[1:0];

    assign accept       = bus.req_valid && (state_q == StRun);
    assign tohost_store = accept && bus.req_wen && (bus.req_addr[3:2] == 2'd0);

`ifndef EXIT_WATCHDOG_EN
    logic unused_params;
    assign unused_params = ^{TIMEOUT_CODE, 32'(TIMEOUT)};
`endif

    always_comb begin
        read_data = '0;
        case (bus.req_addr[3:2])
            2'd0:    read_data = tohost_q;
            2'd1:    read_data = cycle_q;
            default: read_data = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        gp_d         = gp_q;
        tohost_d     = tohost_q;
        cycle_d      = cycle_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;

        if (state_q == StRun) begin
            cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
            if (accept) begin
                resp_valid_d = 1'b1;
                rdata_d      = read_data;
            end
            if (tohost_store) begin
                tohost_d = bus.req_wdata;
            end
            // A reporting store takes precedence over a simultaneous watchdog expiry.
            if (tohost_store && bus.req_wdata[0]) begin
                state_d = StHalted;
                gp_d    = bus.req_wdata;
            end
`ifdef EXIT_WATCHDOG_EN
            else if (cycle_q == 32'(TIMEOUT - 1)) begin
                state_d = StHalted;
                gp_d    = TIMEOUT_CODE;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StRun;
            gp_q         <= '0;
            tohost_q     <= '0;
            cycle_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gp_q         <= gp_d;
            tohost_q     <= tohost_d;
            cycle_q      <= cycle_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign exit           = (state_q == StHalted);
    assign gp             = gp_q;
    assign bus.req_ready  = (state_q == StRun);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_exit_device.sv
// Directed bench for exit_device: scoreboarded responses plus exit/gp/req_ready checks each cycle.
module tb_exit_device;

    logic clk = 1'b0;
    logic rst_n;
    logic exit;
    logic [31:0] gp;

    always #5 clk = ~clk;

    exit_device_if bus ();

    exit_device #(
        .TIMEOUT      (100),
        .TIMEOUT_CODE (32'hFFFF_FFFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .exit  (exit),
        .gp    (gp)
    );

    int          checks = 0;
    int          errors = 0;
    logic        exp_exit;
    logic [31:0] exp_gp;
    logic        acc;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare everything the DUT presents after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (acc) begin
            chk("resp_valid", {31'b0, bus.resp_valid}, 32'd1);
            if (exp_q.size() > 0) chk("resp_rdata", bus.resp_rdata, exp_q.pop_front());
        end else begin
            chk("resp_valid_idle", {31'b0, bus.resp_valid}, 32'd0);
        end
        chk("exit", {31'b0, exit}, {31'b0, exp_exit});
        chk("gp", gp, exp_gp);
        chk("req_ready", {31'b0, bus.req_ready}, {31'b0, !exp_exit});
        acc           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
    endtask

    task automatic req(input logic wen, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic accepted);
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        if (accepted) begin
            acc = 1'b1;
            exp_q.push_back(exp_rdata);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        exp_exit = 1'b0;
        exp_gp   = '0;
        exp_q.delete();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        acc           = 1'b0;

        // Pass exit, then halted with the core retrying.
        do_reset(2);
        req(1'b1, 4'h0, 32'h1, 32'h0, 1'b1);
        exp_exit = 1'b1;
        exp_gp   = 32'h1;
        tick();
        repeat (20) begin
            req(1'b0, 4'h4, 32'h0, 32'h0, 1'b0);
            tick();
        end

        // Non-exit store, ignored stores, reads of RO/reserved, then failing exit.
        do_reset(1);
        req(1'b1, 4'h0, 32'h10, 32'h0, 1'b1);  tick();
        req(1'b0, 4'h0, 32'h0, 32'h10, 1'b1);  tick();
        req(1'b1, 4'h8, 32'h1, 32'h0, 1'b1);   tick();
        req(1'b1, 4'hC, 32'h3, 32'h0, 1'b1);   tick();
        req(1'b0, 4'h8, 32'h0, 32'h0, 1'b1);   tick();
        req(1'b0, 4'hC, 32'h0, 32'h0, 1'b1);   tick();
        req(1'b0, 4'h3, 32'h0, 32'h10, 1'b1);  tick();
        req(1'b1, 4'h0, 32'h7, 32'h10, 1'b1);
        exp_exit = 1'b1;
        exp_gp   = 32'h7;
        tick();
        tick();

        // Reset while halted with a request on the bus: no response, counter restarts.
        req(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        rst_n    = 1'b0;
        exp_exit = 1'b0;
        exp_gp   = '0;
        tick();
        rst_n = 1'b1;
        req(1'b0, 4'h4, 32'h0, 32'd0, 1'b1);  tick();
        req(1'b0, 4'h4, 32'h0, 32'd1, 1'b1);  tick();

        // Reset in the cycle a request would be accepted discards its response.
        req(1'b0, 4'h4, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req(1'b0, 4'h4, 32'h0, 32'd0, 1'b1);  tick();

        // Counter with back-to-back loads.
        do_reset(1);
        repeat (5) tick();
        req(1'b0, 4'h4, 32'h0, 32'd5, 1'b1);  tick();
        req(1'b0, 4'h4, 32'h0, 32'd6, 1'b1);  tick();
        req(1'b0, 4'h4, 32'h0, 32'd7, 1'b1);  tick();

        // Watchdog expiry, or its absence in the default build.
        do_reset(1);
`ifdef EXIT_WATCHDOG_EN
        for (int k = 1; k <= 110; k++) begin
            if (k == 100) begin
                exp_exit = 1'b1;
                exp_gp   = 32'hFFFF_FFFF;
            end
            tick();
        end
`else
        repeat (1000) tick();
        req(1'b0, 4'h4, 32'h0, 32'd1000, 1'b1);  tick();
`endif

        // Store landing on the expiry edge wins over the timeout code.
        do_reset(1);
        repeat (99) tick();
        req(1'b1, 4'h0, 32'h1, 32'h0, 1'b1);
        exp_exit = 1'b1;
        exp_gp   = 32'h1;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exit_device.md
# exit_device

Memory-mapped test-exit ("tohost") device inside `main`, behind the data-bus address decoder. The core stores a status word to it to end a simulation run. The device then raises a sticky `exit` and drives the result on `gp`, which the top-level bench samples (`gp == 1` means pass). An optional watchdog forces an exit with a timeout code if the program never reports.

## Interface
Parameters:
- `TIMEOUT`, default 50000: watchdog limit in clock cycles, counted while in RUN.
- `TIMEOUT_CODE`, default 32'hFFFF_FFFF: value driven on `gp` on a watchdog exit.

Ports:
- `clk` in 1: single clock; all logic updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: bus request. The decoder asserts it only for this device's 16-byte window.
- `req_ready` out 1: request accepted this cycle when `req_valid && req_ready`.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in 4: byte offset within the window. Bits [1:0] are ignored.
- `req_wdata` in 32: store data.
- `resp_valid` out 1: one-cycle acknowledge for every accepted request, loads and stores.
- `resp_rdata` out 32: load data, valid only while `resp_valid` is 1.
- `exit` out 1: sticky halt indication.
- `gp` out 32: exit result.

## Operation
Register map (offset, access):
- 0x0 TOHOST, R/W: last raw value stored. A store with bit0 = 1 triggers exit with `gp` = the raw value. A store with bit0 = 0 only updates the register.
- 0x4 CYCLE, RO: RUN-cycle counter.
- 0x8 FROMHOST, RO: reads 0; stores are ignored.
- 0xC: reserved; reads 0, stores ignored.

State machine, two states:
- RUN, entered on reset. `req_ready` = 1. The counter increments every cycle, saturating at all-ones.
- RUN -> HALTED on an accepted store to 0x0 with `req_wdata[0]` = 1.
  - `gp` <= `req_wdata`.
  - TOHOST <= `req_wdata`.
- RUN -> HALTED on watchdog expiry (see Configuration). `gp` <= `TIMEOUT_CODE`.
- HALTED:
  - `req_ready` = 0, so the core stalls.
  - `exit` = 1; `exit` and `gp` are held until reset.
  - The counter is frozen.
  - No new responses are issued.
- There is no other exit from HALTED; only `rst_n` = 0 leaves it.

Boundary rules:
- A qualifying TOHOST store and watchdog expiry in the same cycle: the store wins and `gp` = the store data.
- A store of exactly 32'h1 gives a pass (`gp` = 1). A store of `(n<<1)|1` reports failing test n.
- A response for the request accepted in the cycle that enters HALTED is still issued, on the following cycle.
- Reset asserted in any state (mid-request or HALTED) returns to RUN on that edge and discards any pending response.

Reset values, applied on a rising edge with `rst_n` = 0:
- State = RUN.
- `exit` = 0, `gp` = 0, TOHOST = 0, counter = 0.
- `resp_valid` = 0, `resp_rdata` = 0, `req_ready` = 1 after reset.

## Timing
- Request accepted at edge N:
  - `resp_valid` = 1 for exactly the cycle after edge N.
  - `resp_rdata` holds the register value sampled at edge N, before that edge's counter increment.
- Loads and stores have the same 1-cycle response latency. A new request may be accepted every cycle, back-to-back.
- Exiting store accepted at edge N: `exit` = 1 and `gp` valid from after edge N, in the same cycle as its `resp_valid`.
- `req_ready` is a registered state decode and drops to 0 in that same cycle.
- Counter: reads 0 in the first cycle after reset, and k after k RUN cycles.
- Watchdog: fires at the edge where the counter equals `TIMEOUT-1`. `exit` = 1 from the following cycle, i.e. `TIMEOUT` cycles after reset release.

## Configuration
- `EXIT_WATCHDOG_EN` defined:
  - The watchdog comparator and timeout transition are compiled in.
  - Expiry exits with `gp` = `TIMEOUT_CODE`.
- `EXIT_WATCHDOG_EN` undefined:
  - No timeout path; HALTED is reachable only by a TOHOST store.
  - The CYCLE counter and its read still exist.
  - The `TIMEOUT` and `TIMEOUT_CODE` parameters are unused.

## Test plan
- Pass exit: reset for 2 cycles, then store 32'h1 to 0x0 -> next cycle `exit` = 1, `gp` = 1, `resp_valid` = 1 for one cycle, `req_ready` = 0; state stays halted for 20 more cycles.
- Fail exit and non-exit store:
  - Store 32'h10 to 0x0 -> no exit; a load from 0x0 returns 32'h10.
  - Then store 32'h7 -> `exit` = 1, `gp` = 7 (test 3 failed).
- Counter and back-to-back loads: after reset, loads of 0x4 accepted at cycles 5, 6, 7 -> responses 5, 6, 7 on consecutive cycles; loads of 0x8 and 0xC return 0.
- Watchdog (`EXIT_WATCHDOG_EN`, `TIMEOUT` = 100): no requests -> `exit` rises exactly 100 cycles after reset release with `gp` = 32'hFFFF_FFFF. Without the macro, `exit` stays 0 for 1000 cycles.
- Collision (`TIMEOUT` = 100): store 32'h1 accepted at the expiry edge (counter = 99) -> `gp` = 1, not `TIMEOUT_CODE`.
- Reset mid-operation: assert `rst_n` = 0 while HALTED and also during a pending response -> next cycle `exit` = 0, `gp` = 0, `resp_valid` = 0, `req_ready` = 1, counter restarts at 0.
